// File: rtl/systemizer_pass_sched_pkg.sv
// systemizer_pass_sched_pkg: shared state encoding, default geometry, pass-type constants and row index type
package systemizer_pass_sched_pkg;
  localparam int DEF_N = 64;
  localparam int DEF_L = 768;
  localparam int DEF_MAX_REDO = 3;
  localparam int P = DEF_L / DEF_N;
  localparam int PW = $clog2(P + 1);
  localparam int CW = $clog2(DEF_L);
  localparam logic PASS_PIVOT = 1'b1;
  localparam logic PASS_REPLAY = 1'b0;
  typedef logic [CW-1:0] row_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_WB,
    S_NEXT,
    S_DONE,
    S_FAILCHK
  } state_t;
endpackage

// File: rtl/systemizer_phase_counter.sv
// systemizer_phase_counter: blk/ph pass counters (clr restarts at the first pivot pass, inc advances one pass) driving phase_id, pivot and the last-pass flag
module systemizer_phase_counter
  import systemizer_pass_sched_pkg::*;
#(
  parameter int NP  = P,
  parameter int NPW = PW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           inc,
  output logic [NPW-1:0] phase_id,
  output logic           pivot,
  output logic           last
);
  logic [NPW-1:0] blk, ph, blk_n, ph_n;
  logic adv_blk;
  always_comb begin
    adv_blk = inc && ph == blk && blk != NPW'(NP - 1);
    ph_n = clr ? '0 : (inc && ph < blk) ? ph + 1'b1 : adv_blk ? '0 : ph;
    blk_n = clr ? '0 : adv_blk ? blk + 1'b1 : blk;
    last = ph == blk && blk == NPW'(NP - 1);
    phase_id = ph;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      blk <= '0;
      ph <= '0;
      pivot <= PASS_REPLAY;
    end else begin
      blk <= blk_n;
      ph <= ph_n;
      pivot <= (clr || inc) ? ((ph_n == blk_n) ? PASS_PIVOT : PASS_REPLAY) : pivot;
    end
  end
endmodule

// File: rtl/systemizer_pass_sched.sv
// systemizer_pass_sched: replay/pivot pass sequencer with abort and bounded redo (start/redo_en in, busy/done/success/attempt status, pivot/pass_start/pass_end/phase_id to memory, dp_done/dp_fail/wb_done back)
module systemizer_pass_sched
  import systemizer_pass_sched_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int L = DEF_L,
  parameter int MAX_REDO = DEF_MAX_REDO
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            redo_en,
  output logic                            busy,
  output logic                            done,
  output logic                            success,
  output logic [$clog2(MAX_REDO+1)-1:0]   attempt,
  output logic                            pivot,
  output logic                            pass_start,
  output logic                            pass_end,
  output logic [$clog2(L/N+1)-1:0]        phase_id,
  input  logic                            dp_done,
  input  logic                            dp_fail,
  input  logic                            wb_done
);
  localparam int PHW = $clog2(L / N + 1);
  localparam int AW = $clog2(MAX_REDO + 1);
  localparam logic [AW-1:0] MAXR = AW'(MAX_REDO);
  state_t state;
  logic last, clr, inc, retry;
  always_comb begin
    retry = redo_en && attempt < MAXR;
    clr = (state == S_IDLE && start) || (state == S_FAILCHK && retry);
    inc = state == S_NEXT && !last;
  end
  systemizer_phase_counter #(.NP(L / N), .NPW(PHW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .inc      (inc),
    .phase_id (phase_id),
    .pivot    (pivot),
    .last     (last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      success <= 1'b0;
      attempt <= '0;
      pass_start <= 1'b0;
      pass_end <= 1'b0;
    end else begin
      pass_start <= 1'b0;
      pass_end <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_ISSUE;
          busy <= 1'b1;
          success <= 1'b0;
          attempt <= '0;
          pass_start <= 1'b1;
        end
        S_ISSUE: state <= S_RUN;
        S_RUN: if (dp_fail && pivot) begin
          state <= S_FAILCHK;
        end else if (dp_done) begin
          pass_end <= 1'b1;
          state <= pivot ? S_WB : S_NEXT;
        end
        S_WB: if (wb_done) state <= S_NEXT;
        S_NEXT: begin
          state <= last ? S_DONE : S_ISSUE;
          pass_start <= !last;
          done <= last;
          success <= last;
          busy <= !last;
        end
        S_FAILCHK: begin
          state <= retry ? S_ISSUE : S_DONE;
          attempt <= retry ? attempt + 1'b1 : attempt;
          pass_start <= retry;
          done <= !retry;
          busy <= retry;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systemizer_pass_sched.sv
// tb_systemizer_pass_sched: directed self-checking bench for systemizer_pass_sched with N=4, L=16, MAX_REDO=3
module tb_systemizer_pass_sched;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, redo_en = 1'b0;
  logic dp_done = 1'b0, dp_fail = 1'b0, wb_done = 1'b0;
  logic busy, done, success, pivot, pass_start, pass_end;
  logic [1:0] attempt;
  logic [2:0] phase_id;
  int checks = 0, failures = 0;
  int n_st = 0, n_end = 0, n_fail = 0;
  logic [2:0] log_ph [0:511];
  logic log_pv [0:511];
  logic [2:0] fail_ph = 3'd0;
  int fail_max = 0, fail_base = 0;
  logic both = 1'b0, replay_fail = 1'b0;
  logic pv, f;
  logic [2:0] ph;
  logic [2:0] exp_ph [10] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};
  logic exp_pv [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int s, e;

  always #5 clk = ~clk;

  systemizer_pass_sched #(.N(4), .L(16), .MAX_REDO(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .redo_en    (redo_en),
    .busy       (busy),
    .done       (done),
    .success    (success),
    .attempt    (attempt),
    .pivot      (pivot),
    .pass_start (pass_start),
    .pass_end   (pass_end),
    .phase_id   (phase_id),
    .dp_done    (dp_done),
    .dp_fail    (dp_fail),
    .wb_done    (wb_done)
  );

  always @(negedge clk) begin
    if (pass_start) begin
      log_ph[n_st] <= phase_id;
      log_pv[n_st] <= pivot;
      n_st <= n_st + 1;
    end
    if (pass_end) n_end <= n_end + 1;
  end

  always begin
    @(negedge clk);
    if (pass_start) begin
      pv = pivot;
      ph = phase_id;
      repeat (5) @(negedge clk);
      f = pv && ph == fail_ph && (n_fail - fail_base) < fail_max;
      dp_done = !f || both;
      dp_fail = f || (!pv && replay_fail);
      if (f) n_fail++;
      @(negedge clk);
      dp_done = 1'b0;
      dp_fail = 1'b0;
      if (pv && !f) begin
        repeat (4) @(negedge clk);
        wb_done = 1'b1;
        @(negedge clk);
        wb_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_pass_start", pass_start, 1);
    chk("lat_phase_pivot", {phase_id, pivot}, {3'd0, 1'b1});
    chk("lat_busy", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!done && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk(tag, done, 1);
  endtask

  task automatic check_seq(input int base);
    for (int i = 0; i < 10; i++)
      chk("seq", {log_ph[base+i], log_pv[base+i]}, {exp_ph[i], exp_pv[i]});
  endtask

  task automatic prep();
    repeat (3) @(negedge clk);
    s = n_st;
    e = n_end;
    fail_base = n_fail;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_flags", {busy, done, success, pivot, pass_start, pass_end}, 0);
    chk("reset_phase", phase_id, 0);
    chk("reset_attempt", attempt, 0);
    rst = 1'b0;
    prep();
    launch();
    wait_done("t1_done");
    chk("t1_success", success, 1);
    chk("t1_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_done_pulse", done, 0);
    chk("t1_start_on_done", busy, 0);
    chk("t1_starts", n_st - s, 10);
    chk("t1_ends", n_end - e, 10);
    check_seq(s);
    fail_ph = 3'd2;
    fail_max = 1;
    prep();
    launch();
    wait_done("t2_done");
    chk("t2_status", {success, attempt, busy}, 0);
    chk("t2_starts", n_st - s, 6);
    chk("t2_ends", n_end - e, 5);
    fail_ph = 3'd0;
    fail_max = 99;
    redo_en = 1'b1;
    prep();
    launch();
    wait_done("t3_done");
    chk("t3_success", success, 0);
    chk("t3_attempt", attempt, 3);
    chk("t3_starts", n_st - s, 4);
    for (int i = 0; i < 4; i++) chk("t3_restart_pos", {log_ph[s+i], log_pv[s+i]}, {3'd0, 1'b1});
    fail_ph = 3'd1;
    fail_max = 1;
    prep();
    launch();
    wait_done("t4_done");
    chk("t4_success", success, 1);
    chk("t4_attempt", attempt, 1);
    chk("t4_starts", n_st - s, 13);
    chk("t4_ends", n_end - e, 12);
    check_seq(s + 3);
    redo_en = 1'b0;
    fail_ph = 3'd0;
    both = 1'b1;
    prep();
    launch();
    wait_done("t5_done");
    chk("t5_success", success, 0);
    chk("t5_starts", n_st - s, 1);
    chk("t5_ends", n_end - e, 0);
    both = 1'b0;
    fail_max = 0;
    replay_fail = 1'b1;
    prep();
    launch();
    wait_done("t6_done");
    chk("t6_success", success, 1);
    chk("t6_ends", n_end - e, 10);
    replay_fail = 1'b0;
    prep();
    launch();
    for (int i = 0; i < 100 && !pass_end; i++) @(negedge clk);
    chk("t7_in_wb", pass_end, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_flags", {busy, done, success, pivot, pass_start, pass_end}, 0);
    chk("t7_rst_phase", {phase_id, attempt}, 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("t7_idle", {busy, done}, 0);
    prep();
    launch();
    chk("t7_attempt", attempt, 0);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t7_done");
    chk("t7_success", success, 1);
    chk("t7_starts", n_st - s, 10);
    check_seq(s);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
